// File: rtl/axi4l_reg_responder.sv
// axi4l_reg_responder: AXI4-Lite slave with NUM_REGS RW registers, a commit counter and an ID word.
// One write outstanding at a time; AW and W are buffered independently and commit together.
module axi4l_reg_responder #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] ID_VALUE           = 32'h4D54_4901
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             wr_pulse
);
    logic        alive, aw_full, w_full, bvalid, rvalid;
    logic [2:0]  aw_slot, ar_slot;
    logic [31:0] w_data, w_mask, wr_cnt, rdata;
    logic [1:0]  bresp, rresp;
    logic [31:0] regs [NUM_REGS];
    logic [31:0] slot_word [8];
    logic [7:0]  slot_rw, slot_ok;
    logic        aw_hs, w_hs, ar_hs, commit;
    logic        unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // alive keeps every READY low while in reset and for the first edge after release
    assign S_AXI_AWREADY = alive && !aw_full && !bvalid;
    assign S_AXI_WREADY  = alive && !w_full && !bvalid;
    assign S_AXI_ARREADY = alive && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit  = aw_full && w_full && !bvalid;
    assign ar_slot = S_AXI_ARADDR[4:2];

    for (genvar i = 0; i < 8; i++) begin : g_slot
        if (i < NUM_REGS) begin : g_rw
            assign slot_word[i] = regs[i];
            assign slot_rw[i]   = 1'b1;
            assign slot_ok[i]   = 1'b1;
        end else if (i == 4) begin : g_cnt
            assign slot_word[i] = wr_cnt;
            assign slot_rw[i]   = 1'b0;
            assign slot_ok[i]   = 1'b1;
        end else if (i == 5) begin : g_id
            assign slot_word[i] = ID_VALUE;
            assign slot_rw[i]   = 1'b0;
            assign slot_ok[i]   = 1'b1;
        end else begin : g_none
            assign slot_word[i] = '0;
            assign slot_rw[i]   = 1'b0;
            assign slot_ok[i]   = 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign reg_out[32*k +: 32] = regs[k];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            alive    <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_slot  <= '0;
            w_data   <= '0;
            w_mask   <= '0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            wr_cnt   <= '0;
            wr_pulse <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            alive    <= 1'b1;
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_slot <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_mask <= {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= slot_rw[aw_slot] ? 2'b00 : 2'b10;
                wr_cnt  <= slot_rw[aw_slot] ? wr_cnt + 32'd1 : wr_cnt;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (aw_slot == 3'(k)) begin
                        regs[k]     <= (regs[k] & ~w_mask) | (w_data & w_mask);
                        wr_pulse[k] <= 1'b1;
                    end
                end
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            // read sees pre-edge state, so a coincident commit is not yet visible
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= slot_word[ar_slot];
                rresp  <= slot_ok[ar_slot] ? 2'b00 : 2'b10;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4l_reg_responder.sv
// tb_axi4l_reg_responder: directed and randomized AXI4-Lite traffic checked against a register-map model.
module tb_axi4l_reg_responder;
    localparam logic [31:0] ID = 32'h4D54_4901;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, wr_pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_out;

    always #5 clk = ~clk;

    axi4l_reg_responder dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] m_regs [4];
    logic [31:0] m_cnt;
    bit          p_valid, r_pend, prev_b, prev_r;
    logic [2:0]  p_slot, r_slot;
    logic [31:0] p_data, exp_rdata;
    logic [3:0]  p_strb, exp_pulse;
    logic [1:0]  exp_rresp, exp_bresp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] s);
        return s < 3'd4 ? m_regs[s[1:0]] : s == 3'd4 ? m_cnt : s == 3'd5 ? ID : 32'd0;
    endfunction

    // Reference: read results from the pre-edge map, then apply any write whose response just appeared
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (rvalid && !prev_r) begin
                check("r_spurious", r_pend, 1);
                exp_rdata = m_read(r_slot);
                exp_rresp = r_slot <= 3'd5 ? 2'b00 : 2'b10;
                r_pend = 1'b0;
            end
            if (rvalid) begin
                check("rdata", rdata, exp_rdata);
                check("rresp", rresp, exp_rresp);
            end
            exp_pulse = '0;
            if (bvalid && !prev_b) begin
                check("b_spurious", p_valid, 1);
                if (p_slot < 3'd4) begin
                    for (int b = 0; b < 4; b++)
                        if (p_strb[b]) m_regs[p_slot[1:0]][8*b +: 8] = p_data[8*b +: 8];
                    m_cnt = m_cnt + 1;
                    exp_pulse[p_slot[1:0]] = 1'b1;
                    exp_bresp = 2'b00;
                end else begin
                    exp_bresp = 2'b10;
                end
                p_valid = 1'b0;
            end
            if (bvalid) check("bresp", bresp, exp_bresp);
            check("wr_pulse", wr_pulse, exp_pulse);
            check("reg_out", reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            check("ready_while_valid", (awready && bvalid) || (wready && bvalid) || (arready && rvalid), 0);
            prev_b = bvalid;
            prev_r = rvalid;
        end
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start, input int b_delay, output logic [1:0] br);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int t = 0, lat = 0;
        p_slot = addr[4:2]; p_data = data; p_strb = strb; p_valid = 1'b1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = (aw_start == 0);
        wvalid = (w_start == 0);
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= hs_aw;
            w_done |= hs_w;
            t++;
            awvalid = !aw_done && t >= aw_start;
            wvalid = !w_done && t >= w_start;
            if (t > 50) begin
                check("write_timeout", 1, 0);
                p_valid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; br = 2'bxx;
                return;
            end
        end
        do begin @(negedge clk); lat++; end while (!bvalid && lat < 20);
        check("b_latency", lat, 2);
        br = bresp;
        repeat (b_delay) begin @(posedge clk); #1; end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] addr, input int r_delay, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        r_slot = addr[4:2]; r_pend = 1'b1;
        araddr = addr; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) begin
            check("ar_timeout", 1, 0);
            arvalid = 1'b0; r_pend = 1'b0; d = 'x; r = 'x;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        check("r_latency", n, 1);
        d = rdata; r = rresp;
        repeat (r_delay) begin
            @(posedge clk); #1;
            check("rdata_hold", rdata, d);
            check("arready_low", arready, 0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic check_idle_outputs();
        check("rst_awready", awready, 0); check("rst_wready", wready, 0); check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);   check("rst_rvalid", rvalid, 0); check("rst_rdata", rdata, 0);
        check("rst_bresp", bresp, 0);     check("rst_rresp", rresp, 0);   check("rst_reg_out", reg_out, 0);
        check("rst_wr_pulse", wr_pulse, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r, br;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_cnt = '0; p_valid = 0; r_pend = 0;
        #12;
        check_idle_outputs();
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, br);
        for (int i = 0; i < 4; i++) begin
            do_read(5'(4 * i), 0, d, r);
            check("basic_read", d, i + 1);
            check("basic_rresp", r, 0);
        end
        do_read(5'h10, 0, d, r); check("counter_read", d, 4);
        do_read(5'h14, 0, d, r); check("id_read", d, ID);

        do_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0, br);
        do_write(5'h00, 32'h11223344, 4'h5, 0, 0, 0, br);
        do_read(5'h00, 0, d, r); check("strobe_merge", d, 32'hAA22CC44);

        do_write(5'h08, 32'h77, 4'hF, 3, 0, 5, br); check("w_first_bresp", br, 0);
        do_write(5'h0C, 32'h88, 4'hF, 0, 0, 0, br); check("after_b_bresp", br, 0);

        do_write(5'h18, 32'hDEAD, 4'hF, 0, 0, 0, br); check("unmapped_bresp", br, 2);
        do_write(5'h14, 32'hBEEF, 4'hF, 0, 0, 0, br); check("ro_bresp", br, 2);
        do_read(5'h1C, 0, d, r); check("unmapped_rdata", d, 0); check("unmapped_rresp", r, 2);
        do_read(5'h10, 0, d, r); check("counter_unchanged", d, 8);

        fork
            do_write(5'h04, 32'h5555, 4'hF, 0, 0, 0, br);
            begin @(posedge clk); #1; do_read(5'h04, 4, d, r); end
        join
        check("coincident_old", d, 2);
        do_read(5'h04, 0, d, r); check("coincident_new", d, 32'h5555);

        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 2);
            logic [4:0] wa = 5'($urandom_range(0, 31));
            logic [4:0] ra = 5'($urandom_range(0, 31));
            if (op == 0) do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
            else if (op == 1) do_read(ra, $urandom_range(0, 3), d, r);
            else begin
                int off = $urandom_range(0, 3);
                fork
                    do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br);
                    begin repeat (off) begin @(posedge clk); #1; end do_read(ra, $urandom_range(0, 3), d, r); end
                join
            end
        end

        awaddr = 5'h00; awvalid = 1'b1;
        do @(negedge clk); while (!awready);
        @(posedge clk); #1;
        awvalid = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_cnt = '0;
        #1;
        check_idle_outputs();
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("no_b_after_reset", bvalid, 0);
        do_read(5'h00, 0, d, r); check("reg0_after_reset", d, 0);
        do_read(5'h10, 0, d, r); check("cnt_after_reset", d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4l_reg_responder.md
Name: axi4l_reg_responder

Overview:
- AXI4-Lite slave register file that completes transactions issued by the system's AXI4-Lite master, i.e. the responder end of the control bus.
- Provides NUM_REGS read/write control registers, a read-only committed-write counter and a read-only ID word.
- Register contents and per-register write strobes are driven into fabric logic.
- Sits behind the interconnect in the block design, clocked and reset with the bus.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; fixed at 32, other values unsupported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; gives 8 word slots.
- NUM_REGS, 4, number of read/write registers at slots 0..NUM_REGS-1; legal range 1..4.
- ID_VALUE, 32'h4D54_4901, constant returned from the ID slot.

Ports:
- S_AXI_ACLK in 1: bus clock.
- S_AXI_ARESETN in 1: asynchronous active-low reset.
- S_AXI_AWADDR in 5: write address.
- S_AXI_AWPROT in 3: ignored.
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
- S_AXI_WDATA in 32: write data.
- S_AXI_WSTRB in 4: write byte enables.
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response.
- S_AXI_ARADDR in 5: read address.
- S_AXI_ARPROT in 3: ignored.
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake.
- S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data.
- reg_out out NUM_REGS*32: register contents; reg k occupies bits [32k+31:32k].
- wr_pulse out NUM_REGS: one-cycle pulse on the commit of a write to reg k.

Behaviour:
- Reset, asynchronous: every output 0 (READYs, VALIDs, RDATA, BRESP, RRESP, reg_out, wr_pulse); all registers 0; write counter 0; AW and W holding buffers empty. Reset mid-transaction discards it: no partial register update and no response issued after reset release.
- Address decode uses ADDR[4:2]; ADDR[1:0] are ignored.
  - Slots 0..NUM_REGS-1: RW registers.
  - Slot 4: write counter (RO).
  - Slot 5: ID_VALUE (RO).
  - Slots 6, 7, and RW slots >= NUM_REGS: unmapped.
- Write path: AW and W are accepted independently in any order.
  - AWREADY = !aw_full && !BVALID.
  - WREADY = !w_full && !BVALID.
  - A handshake sets the matching full flag and latches the address or data+strobe.
- Write commit: on the first edge where aw_full && w_full && !BVALID:
  - RW slot: bytes with WSTRB[b]=1 are updated, others are kept; BRESP=00; counter increments (32-bit, wraps FFFF_FFFF->0); wr_pulse[k]=1 for that cycle.
  - RO or unmapped slot: no state change; BRESP=10 (SLVERR); counter unchanged.
  - BVALID=1, both full flags clear.
- Minimum latency: AW and W handshaken on edge N -> BVALID high after edge N+1.
- BVALID, BRESP hold until the BREADY handshake. No new AW/W is accepted while BVALID=1, so at most one write is outstanding.
- Read path: ARREADY = !RVALID.
  - On the AR handshake edge, RDATA and RRESP are registered from the current (pre-edge) state and RVALID=1. RDATA/RVALID appear 1 cycle after the AR handshake.
  - Unmapped slot: RDATA=0, RRESP=10.
  - RVALID, RDATA, RRESP hold until RREADY; RVALID falls on the handshake edge.
- Simultaneous read and write commit to the same register on one edge: the read returns the old value; the new value is visible to later reads.
- A counter read coincident with a commit returns the pre-increment value.
- Read and write paths are fully independent; neither stalls the other.
- AXI rule: no READY or VALID output depends combinationally on an input VALID/READY of the same cycle; all are registered.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 1,2,3,4 with RRESP=00; read 0x10 -> 4; read 0x14 -> 4D544901; wr_pulse fires once per register.
- Write 0xAABBCCDD to 0x0 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5 -> read 0x0 = AA22CC44.
- Present W 3 cycles before AW with BREADY held low 5 cycles -> AWREADY=WREADY=0 while BVALID=1; BRESP=00 held until BREADY; next write is accepted after the B handshake.
- Write 0x18 and 0x14, then read 0x1C -> BRESP=10 and RRESP=10, RDATA=0; registers and counter unchanged.
- Issue an AR to 0x4 on the same edge as the commit of 0x5555 to 0x4 (old value 0x2) -> RDATA=0x2; the following read returns 0x5555. RREADY held low 4 cycles -> RDATA stable, ARREADY=0.
- Assert reset between the AW handshake and the W handshake -> all outputs 0 immediately; after release, no BVALID appears and reg 0 reads 0.
